// File: rtl/icache.sv
// Direct-mapped, read-only instruction cache with 32-byte lines refilled as
// four 64-bit beats from a simple request/response memory port.
`timescale 1ns/1ps
module icache #(
   parameter int SETS = 16
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        ifu_ren,
   input  logic [31:0] ifu_addr,
   output logic        ifu_hit,
   output logic [63:0] ifu_rdata,
   output logic        ifu_rvalid,
   input  logic        fence_i,
   output logic        mem_req_valid,
   input  logic        mem_req_ready,
   output logic [31:0] mem_req_addr,
   input  logic        mem_resp_valid,
   input  logic [63:0] mem_resp_data
);
   localparam int IDX_W = $clog2(SETS);
   localparam int TAG_W = 27 - IDX_W;

   typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, REFILL = 2'd2} state_e;

   state_e            state_q;
   logic [SETS-1:0]   valid_q;
   logic [TAG_W-1:0]  tag_q  [SETS];
   logic [63:0]       data_q [SETS][4];
   logic [31:3]       addr_q;
   logic [1:0]        cnt_q;
   logic              fence_pend_q;
   logic [63:0]       rdata_q;
   logic              rvalid_q;
   logic              req_valid_q;
   logic [31:0]       req_addr_q;

   logic [IDX_W-1:0]  in_idx, lat_idx;
   logic [TAG_W-1:0]  in_tag, lat_tag;
   logic [1:0]        in_beat, lat_beat;
   logic              beat_fire, last_beat;
   logic              unused_addr;

   assign in_idx   = ifu_addr[5 +: IDX_W];
   assign in_tag   = ifu_addr[31 -: TAG_W];
   assign in_beat  = ifu_addr[4:3];
   assign lat_idx  = addr_q[5 +: IDX_W];
   assign lat_tag  = addr_q[31 -: TAG_W];
   assign lat_beat = addr_q[4:3];
   assign unused_addr = ^ifu_addr[2:0];

   assign ifu_hit = ifu_ren && (state_q == IDLE) && valid_q[in_idx] &&
                    (tag_q[in_idx] == in_tag) && !fence_i;

   assign beat_fire = (state_q == REFILL) && mem_resp_valid;
   assign last_beat = beat_fire && (cnt_q == 2'd3);

   assign ifu_rdata     = rdata_q;
   assign ifu_rvalid    = rvalid_q;
   assign mem_req_valid = req_valid_q;
   assign mem_req_addr  = req_addr_q;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= IDLE;
         valid_q      <= '0;
         cnt_q        <= 2'd0;
         fence_pend_q <= 1'b0;
         rdata_q      <= '0;
         rvalid_q     <= 1'b0;
         req_valid_q  <= 1'b0;
         req_addr_q   <= '0;
      end else begin
         rvalid_q <= 1'b0;
         // A fence seen at any point during the refill keeps the new line invalid.
         if (fence_i)
            valid_q <= '0;
         else if (last_beat && !fence_pend_q)
            valid_q[lat_idx] <= 1'b1;
         case (state_q)
            IDLE: begin
               if (ifu_ren) begin
                  if (ifu_hit) begin
                     rdata_q <= data_q[in_idx][in_beat];
                  end else begin
                     addr_q       <= ifu_addr[31:3];
                     req_addr_q   <= {ifu_addr[31:5], 5'b0};
                     req_valid_q  <= 1'b1;
                     fence_pend_q <= 1'b0;
                     cnt_q        <= 2'd0;
                     state_q      <= REQ;
                  end
               end
            end
            REQ: begin
               if (fence_i) fence_pend_q <= 1'b1;
               if (req_valid_q && mem_req_ready) begin
                  req_valid_q <= 1'b0;
                  state_q     <= REFILL;
               end
            end
            REFILL: begin
               if (fence_i) fence_pend_q <= 1'b1;
               if (mem_resp_valid) begin
                  cnt_q <= cnt_q + 2'd1;
                  if (cnt_q == lat_beat) rdata_q <= mem_resp_data;
                  if (cnt_q == 2'd3) begin
                     state_q  <= IDLE;
                     rvalid_q <= 1'b1;
                  end
               end
            end
            default: begin
               state_q     <= IDLE;
               req_valid_q <= 1'b0;
            end
         endcase
      end
   end

   // Line storage is not reset; the valid bits alone gate its use.
   always_ff @(posedge clock) begin
      if (!reset && beat_fire) begin
         data_q[lat_idx][cnt_q] <= mem_resp_data;
         if (cnt_q == 2'd3) tag_q[lat_idx] <= lat_tag;
      end
   end

endmodule

// File: tb/tb_icache.sv
// Directed bench for icache: cold miss, hit, conflict, backpressure,
// fence_i during refill and in IDLE, and reset during refill.
`timescale 1ns/1ps
module tb_icache;
   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        ifu_ren = 1'b0;
   logic [31:0] ifu_addr = '0;
   logic        ifu_hit;
   logic [63:0] ifu_rdata;
   logic        ifu_rvalid;
   logic        fence_i = 1'b0;
   logic        mem_req_valid;
   logic        mem_req_ready = 1'b1;
   logic [31:0] mem_req_addr;
   logic        mem_resp_valid = 1'b0;
   logic [63:0] mem_resp_data = '0;

   int vecs = 0;
   int errs = 0;
   int rv_early = 0;

   localparam logic [63:0] LA = 64'hA000_0000_0000_000A, LB = 64'hB000_0000_0000_000B;
   localparam logic [63:0] LC = 64'hC000_0000_0000_000C, LD = 64'hD000_0000_0000_000D;
   localparam logic [63:0] E0 = 64'hE000_0000_0000_0E00, E1 = 64'hE000_0000_0000_0E01;
   localparam logic [63:0] E2 = 64'hE000_0000_0000_0E02, E3 = 64'hE000_0000_0000_0E03;
   localparam logic [63:0] F0 = 64'hF000_0000_0000_0F00, F1 = 64'hF000_0000_0000_0F01;
   localparam logic [63:0] F2 = 64'hF000_0000_0000_0F02, F3 = 64'hF000_0000_0000_0F03;

   icache #(.SETS(16)) dut (
      .clock(clock), .reset(reset), .ifu_ren(ifu_ren), .ifu_addr(ifu_addr),
      .ifu_hit(ifu_hit), .ifu_rdata(ifu_rdata), .ifu_rvalid(ifu_rvalid),
      .fence_i(fence_i), .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
      .mem_req_addr(mem_req_addr), .mem_resp_valid(mem_resp_valid),
      .mem_resp_data(mem_resp_data)
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Drives four refill beats with `gap` idle cycles between them; fence_i
   // accompanies beat number fence_at (-1 for none). Counts early rvalid.
   task automatic beats(input logic [63:0] b0, b1, b2, b3, input int gap, input int fence_at);
      logic [63:0] b [4];
      b = '{b0, b1, b2, b3};
      rv_early = 0;
      for (int i = 0; i < 4; i++) begin
         mem_resp_valid = 1'b1;
         mem_resp_data  = b[i];
         fence_i        = (i == fence_at);
         tick();
         mem_resp_valid = 1'b0;
         mem_resp_data  = '0;
         fence_i        = 1'b0;
         if (i < 3) begin
            if (ifu_rvalid) rv_early++;
            for (int g = 0; g < gap; g++) begin
               tick();
               if (ifu_rvalid) rv_early++;
            end
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; ifu_ren = 1'b1; ifu_addr = 32'h8000_0008;
      tick(); tick();
      vecs++; if (ifu_hit !== 1'b0) begin errs++; $display("FAIL rst_hit: got %b want 0", ifu_hit); end
      vecs++; if (mem_req_valid !== 1'b0) begin errs++; $display("FAIL rst_req_valid: got %b want 0", mem_req_valid); end
      vecs++; if (mem_req_addr !== 32'h0) begin errs++; $display("FAIL rst_req_addr: got %h want 0", mem_req_addr); end
      vecs++; if (ifu_rdata !== 64'h0) begin errs++; $display("FAIL rst_rdata: got %h want 0", ifu_rdata); end
      vecs++; if (ifu_rvalid !== 1'b0) begin errs++; $display("FAIL rst_rvalid: got %b want 0", ifu_rvalid); end
      ifu_ren = 1'b0; reset = 1'b0;
      tick();
   endtask

   task automatic test_cold_miss();
      ifu_ren = 1'b1; ifu_addr = 32'h8000_0008; #1;
      vecs++; if (ifu_hit !== 1'b0) begin errs++; $display("FAIL cold_hit: got %b want 0", ifu_hit); end
      tick(); ifu_ren = 1'b0;
      vecs++; if (mem_req_valid !== 1'b1) begin errs++; $display("FAIL cold_req_valid: got %b want 1", mem_req_valid); end
      vecs++; if (mem_req_addr !== 32'h8000_0000) begin errs++; $display("FAIL cold_req_addr: got %h want 80000000", mem_req_addr); end
      tick();
      vecs++; if (mem_req_valid !== 1'b0) begin errs++; $display("FAIL cold_req_drop: got %b want 0", mem_req_valid); end
      beats(LA, LB, LC, LD, 0, -1);
      vecs++; if (rv_early !== 0) begin errs++; $display("FAIL cold_rv_early: got %0d want 0", rv_early); end
      vecs++; if (ifu_rvalid !== 1'b1) begin errs++; $display("FAIL cold_rvalid: got %b want 1", ifu_rvalid); end
      vecs++; if (ifu_rdata !== LB) begin errs++; $display("FAIL cold_rdata: got %h want %h", ifu_rdata, LB); end
      tick();
      vecs++; if (ifu_rvalid !== 1'b0) begin errs++; $display("FAIL cold_rv_pulse: got %b want 0", ifu_rvalid); end
   endtask

   task automatic test_hit();
      ifu_ren = 1'b1; ifu_addr = 32'h8000_0018; #1;
      vecs++; if (ifu_hit !== 1'b1) begin errs++; $display("FAIL hit_flag: got %b want 1", ifu_hit); end
      tick(); ifu_ren = 1'b0;
      vecs++; if (ifu_rdata !== LD) begin errs++; $display("FAIL hit_rdata: got %h want %h", ifu_rdata, LD); end
      vecs++; if (mem_req_valid !== 1'b0) begin errs++; $display("FAIL hit_no_req: got %b want 0", mem_req_valid); end
      vecs++; if (ifu_rvalid !== 1'b0) begin errs++; $display("FAIL hit_no_rvalid: got %b want 0", ifu_rvalid); end
      tick(); tick(); tick();
      vecs++; if (ifu_rdata !== LD) begin errs++; $display("FAIL hit_hold: got %h want %h", ifu_rdata, LD); end
      ifu_ren = 1'b1; ifu_addr = 32'h8000_0000; #1;
      vecs++; if (ifu_hit !== 1'b1) begin errs++; $display("FAIL hit0_flag: got %b want 1", ifu_hit); end
      tick(); ifu_ren = 1'b0;
      vecs++; if (ifu_rdata !== LA) begin errs++; $display("FAIL hit0_rdata: got %h want %h", ifu_rdata, LA); end
   endtask

   task automatic test_conflict();
      ifu_ren = 1'b1; ifu_addr = 32'h8000_0200; #1;
      vecs++; if (ifu_hit !== 1'b0) begin errs++; $display("FAIL conf_hit: got %b want 0", ifu_hit); end
      tick(); ifu_ren = 1'b0;
      vecs++; if (mem_req_addr !== 32'h8000_0200) begin errs++; $display("FAIL conf_req_addr: got %h want 80000200", mem_req_addr); end
      tick();
      beats(E0, E1, E2, E3, 0, -1);
      vecs++; if (ifu_rdata !== E0) begin errs++; $display("FAIL conf_rdata: got %h want %h", ifu_rdata, E0); end
      tick();
      ifu_ren = 1'b1; ifu_addr = 32'h8000_0000; #1;
      vecs++; if (ifu_hit !== 1'b0) begin errs++; $display("FAIL conf_evict: got %b want 0", ifu_hit); end
      tick(); ifu_ren = 1'b0;
      vecs++; if (mem_req_addr !== 32'h8000_0000) begin errs++; $display("FAIL conf_req2: got %h want 80000000", mem_req_addr); end
      tick();
      beats(LA, LB, LC, LD, 0, -1);
      vecs++; if (ifu_rdata !== LA) begin errs++; $display("FAIL conf_rdata2: got %h want %h", ifu_rdata, LA); end
      tick();
      ifu_ren = 1'b1; ifu_addr = 32'h8000_0008; #1;
      vecs++; if (ifu_hit !== 1'b1) begin errs++; $display("FAIL conf_rehit: got %b want 1", ifu_hit); end
      ifu_ren = 1'b0;
      tick();
   endtask

   task automatic test_backpressure();
      int bad;
      logic [63:0] p [4];
      p = '{64'h1111_0000_0000_0001, 64'h2222_0000_0000_0002,
            64'h3333_0000_0000_0003, 64'h4444_0000_0000_0004};
      bad = 0;
      mem_req_ready = 1'b0;
      ifu_ren = 1'b1; ifu_addr = 32'h8000_0048;
      tick(); ifu_ren = 1'b0;
      for (int i = 0; i < 5; i++) begin
         if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h8000_0040) bad++;
         tick();
      end
      vecs++; if (bad !== 0) begin errs++; $display("FAIL bp_stable: got %0d unstable cycles want 0", bad); end
      vecs++; if (mem_req_valid !== 1'b1) begin errs++; $display("FAIL bp_still_valid: got %b want 1", mem_req_valid); end
      mem_req_ready = 1'b1;
      tick();
      vecs++; if (mem_req_valid !== 1'b0) begin errs++; $display("FAIL bp_req_drop: got %b want 0", mem_req_valid); end
      beats(p[0], p[1], p[2], p[3], 2, -1);
      vecs++; if (rv_early !== 0) begin errs++; $display("FAIL bp_rv_early: got %0d want 0", rv_early); end
      vecs++; if (ifu_rvalid !== 1'b1) begin errs++; $display("FAIL bp_rvalid: got %b want 1", ifu_rvalid); end
      vecs++; if (ifu_rdata !== p[1]) begin errs++; $display("FAIL bp_rdata: got %h want %h", ifu_rdata, p[1]); end
      tick();
      vecs++; if (ifu_rvalid !== 1'b0) begin errs++; $display("FAIL bp_rv_pulse: got %b want 0", ifu_rvalid); end
      for (int i = 0; i < 4; i++) begin
         ifu_ren = 1'b1; ifu_addr = 32'h8000_0040 + 32'(8 * i); #1;
         vecs++; if (ifu_hit !== 1'b1) begin errs++; $display("FAIL bp_hit%0d: got %b want 1", i, ifu_hit); end
         tick();
         vecs++; if (ifu_rdata !== p[i]) begin errs++; $display("FAIL bp_beat%0d: got %h want %h", i, ifu_rdata, p[i]); end
      end
      ifu_ren = 1'b0;
   endtask

   task automatic test_fence_refill();
      ifu_ren = 1'b1; ifu_addr = 32'h8000_0088;
      tick(); ifu_ren = 1'b0;
      tick();
      beats(F0, F1, F2, F3, 0, 1);
      vecs++; if (ifu_rvalid !== 1'b1) begin errs++; $display("FAIL fr_rvalid: got %b want 1", ifu_rvalid); end
      vecs++; if (ifu_rdata !== F1) begin errs++; $display("FAIL fr_rdata: got %h want %h", ifu_rdata, F1); end
      tick();
      ifu_ren = 1'b1; ifu_addr = 32'h8000_0040; #1;
      vecs++; if (ifu_hit !== 1'b0) begin errs++; $display("FAIL fr_clear_all: got %b want 0", ifu_hit); end
      ifu_addr = 32'h8000_0088; #1;
      vecs++; if (ifu_hit !== 1'b0) begin errs++; $display("FAIL fr_line_invalid: got %b want 0", ifu_hit); end
      tick(); ifu_ren = 1'b0;
      vecs++; if (mem_req_valid !== 1'b1) begin errs++; $display("FAIL fr_remiss: got %b want 1", mem_req_valid); end
      tick();
      beats(F0, F1, F2, F3, 0, -1);
      tick();
      ifu_ren = 1'b1; #1;
      vecs++; if (ifu_hit !== 1'b1) begin errs++; $display("FAIL fr_clean_fill: got %b want 1", ifu_hit); end
      ifu_ren = 1'b0;
      tick();
   endtask

   task automatic test_fence_idle();
      ifu_ren = 1'b1; ifu_addr = 32'h8000_0088; fence_i = 1'b1; #1;
      vecs++; if (ifu_hit !== 1'b0) begin errs++; $display("FAIL fi_hit: got %b want 0", ifu_hit); end
      tick(); ifu_ren = 1'b0; fence_i = 1'b0;
      vecs++; if (mem_req_valid !== 1'b1) begin errs++; $display("FAIL fi_forced_miss: got %b want 1", mem_req_valid); end
      tick();
      beats(F0, F1, F2, F3, 0, -1);
      tick();
      ifu_ren = 1'b1; #1;
      vecs++; if (ifu_hit !== 1'b1) begin errs++; $display("FAIL fi_refilled: got %b want 1", ifu_hit); end
      ifu_ren = 1'b0;
      tick();
   endtask

   task automatic test_reset_refill();
      int rv;
      rv = 0;
      ifu_ren = 1'b1; ifu_addr = 32'h8000_00C0;
      tick(); ifu_ren = 1'b0;
      tick();
      mem_resp_valid = 1'b1; mem_resp_data = LA; tick();
      mem_resp_data = LB; tick();
      mem_resp_data = LC; reset = 1'b1; tick();
      reset = 1'b0; mem_resp_valid = 1'b0;
      vecs++; if (mem_req_valid !== 1'b0) begin errs++; $display("FAIL rr_req_valid: got %b want 0", mem_req_valid); end
      vecs++; if (ifu_rdata !== 64'h0) begin errs++; $display("FAIL rr_rdata: got %h want 0", ifu_rdata); end
      mem_resp_valid = 1'b1; mem_resp_data = LD;
      tick(); if (ifu_rvalid) rv++;
      mem_resp_data = LA;
      tick(); if (ifu_rvalid) rv++;
      mem_resp_valid = 1'b0;
      tick(); if (ifu_rvalid) rv++;
      vecs++; if (rv !== 0) begin errs++; $display("FAIL rr_no_rvalid: got %0d pulses want 0", rv); end
      vecs++; if (ifu_rdata !== 64'h0) begin errs++; $display("FAIL rr_beats_ignored: got %h want 0", ifu_rdata); end
      ifu_ren = 1'b1; ifu_addr = 32'h8000_00C0; #1;
      vecs++; if (ifu_hit !== 1'b0) begin errs++; $display("FAIL rr_hit: got %b want 0", ifu_hit); end
      tick(); ifu_ren = 1'b0;
      vecs++; if (mem_req_valid !== 1'b1) begin errs++; $display("FAIL rr_remiss: got %b want 1", mem_req_valid); end
      reset = 1'b1; tick(); reset = 1'b0; tick();
   endtask

   initial begin
      #1;
      test_reset();
      test_cold_miss();
      test_hit();
      test_conflict();
      test_backpressure();
      test_fence_refill();
      test_fence_idle();
      test_reset_refill();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule

// File: doc/icache.md
ICACHE -- requirements
Module: icache

Interface
REQ-001 Parameter SETS, default 16, number of direct-mapped lines; power of two, at least 2; line size fixed at 32 bytes (4 x 64-bit beats).
REQ-002 clock  input  1  clock, all state updates on rising edge.
REQ-003 reset  input  1  reset, synchronous, active-high.
REQ-004 ifu_ren  input  1  lookup request, sampled only in IDLE.
REQ-005 ifu_addr  input  32  fetch address, valid with ifu_ren; bits [2:0] ignored.
REQ-006 ifu_hit  output  1  combinational hit indication for the current lookup.
REQ-007 ifu_rdata  output  64  registered 64-bit beat containing the fetched instruction.
REQ-008 ifu_rvalid  output  1  one-cycle pulse, miss data ready.
REQ-009 fence_i  input  1  invalidate-all pulse.
REQ-010 mem_req_valid  output  1  line refill request valid.
REQ-011 mem_req_ready  input  1  backing memory accepts request.
REQ-012 mem_req_addr  output  32  line-aligned refill address.
REQ-013 mem_resp_valid  input  1  refill beat valid; no backpressure.
REQ-014 mem_resp_data  input  64  refill beat data, ascending beat order from line base.

Function
REQ-015 Address split SHALL be: beat = addr[4:3], index = addr[4+log2(SETS):5], tag = remaining upper bits.
REQ-016 Storage SHALL be per line: valid bit, tag, 4 x 64-bit data.
REQ-017 States SHALL be IDLE, REQ, REFILL; no other encodings reachable; illegal encoding returns to IDLE.
REQ-018 ifu_hit SHALL equal ifu_ren & IDLE & valid[index] & tag match & !fence_i; 0 in all other states.
REQ-019 On hit, ifu_rdata SHALL update at the next edge to data[index][beat]; no memory request issued; state stays IDLE.
REQ-020 ifu_rdata SHALL hold its value until the next hit or miss completion.
REQ-021 On ifu_ren in IDLE without hit, the cache SHALL latch address and enter REQ next cycle.
REQ-022 In REQ, mem_req_valid SHALL be 1 and mem_req_addr = {latched addr[31:5], 5'b0}, both stable until mem_req_valid & mem_req_ready, then enter REFILL.
REQ-023 In REFILL, a 2-bit beat counter starting at 0 SHALL write each mem_resp_valid beat into data[index][counter] and increment.
REQ-024 When counter equals the latched beat, the response data SHALL also be captured into ifu_rdata.
REQ-025 On the 4th beat the cache SHALL write tag, set valid (unless REQ-028 applies), return to IDLE, and pulse ifu_rvalid in the following cycle.
REQ-026 Miss latency SHALL be: REQ entry 1 cycle after ifu_ren; ifu_rvalid 1 cycle after the 4th beat.
REQ-027 mem_resp_valid outside REFILL and ifu_ren outside IDLE SHALL be ignored.
REQ-028 fence_i SHALL clear all valid bits at the next edge; if asserted during REQ or REFILL, the in-flight line SHALL complete and return data with ifu_rvalid but remain invalid.
REQ-029 fence_i coincident with ifu_ren in IDLE SHALL force a miss.
REQ-030 A line refill SHALL overwrite any previous tag at that index (no victim write-back; read-only cache).

Reset
REQ-031 On reset: state IDLE, all valid bits 0, ifu_rdata 0, ifu_rvalid 0, mem_req_valid 0, mem_req_addr 0, beat counter 0; tags and data not reset.
REQ-032 Reset mid-REQ or mid-REFILL SHALL abandon the refill; later beats ignored; no ifu_rvalid pulse.

Verification
REQ-033 Cold miss: SETS=16, ren addr 0x80000008 -> hit=0, mem_req_addr=0x80000000; beats A,B,C,D -> ifu_rvalid 1 cycle after D, ifu_rdata=B.
REQ-034 Hit after fill: ren 0x80000018 -> hit=1 same cycle, ifu_rdata=D next cycle, mem_req_valid stays 0.
REQ-035 Conflict: ren 0x80000200 -> miss, refill index 0; then ren 0x80000000 -> miss again.
REQ-036 Backpressure: mem_req_ready low 5 cycles, resp_valid with 2-cycle gaps -> req_valid/addr stable, 4 beats stored correctly, single rvalid pulse.
REQ-037 fence_i during REFILL -> rvalid with correct data; next ren same addr misses.
REQ-038 reset during beat 2 -> mem_req_valid 0, no rvalid, remaining beats ignored, next ren same addr misses.
